// File: rtl/vigna_irq_pkg.sv
// -----------------------------------------------------------------------------
// vigna_irq_pkg
// Shared constants for the Vigna external-interrupt controller: register
// offsets inside the 4 KiB slave window, interrupt-ID width and the
// "no interrupt" ID.
// -----------------------------------------------------------------------------
package vigna_irq_pkg;

   localparam int unsigned ID_W = 5;

   localparam logic [ID_W-1:0] ID_NONE = 5'd0;

   localparam logic [11:0] OFF_PENDING   = 12'h000;
   localparam logic [11:0] OFF_ENABLE    = 12'h004;
   localparam logic [11:0] OFF_MODE      = 12'h008;
   localparam logic [11:0] OFF_THRESH    = 12'h00C;
   localparam logic [11:0] OFF_CLAIM     = 12'h010;
   localparam logic [11:0] OFF_PRIO_BASE = 12'h040;

endpackage

// File: rtl/vigna_irq_arbiter.sv
// -----------------------------------------------------------------------------
// vigna_irq_arbiter
// Purely combinational priority arbiter. Picks the highest-priority source in
// the candidate mask; ties go to the lowest ID. A priority of 0 never wins.
// Ports:
//   cand      [NUM_SRC:1]          candidate mask, bit i = source ID i
//   prio_vec  [NUM_SRC*PRIO_W-1:0] priorities, source i at slice i-1
//   win_id    [ID_W-1:0]           winning ID, 0 when no candidate
//   win_prio  [PRIO_W-1:0]         priority of the winner, 0 when none
// -----------------------------------------------------------------------------
module vigna_irq_arbiter
   import vigna_irq_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned PRIO_W  = 3
) (
   input  logic [NUM_SRC:1]          cand,
   input  logic [NUM_SRC*PRIO_W-1:0] prio_vec,
   output logic [ID_W-1:0]           win_id,
   output logic [PRIO_W-1:0]         win_prio
);

   logic take_s;

   // Ascending scan with strict '>' keeps the lowest ID on equal priority.
   always_comb begin
      win_id   = ID_NONE;
      win_prio = {PRIO_W{1'b0}};
      take_s   = 1'b0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         take_s   = cand[i] && (prio_vec[(i-1)*PRIO_W +: PRIO_W] > win_prio);
         win_id   = take_s ? ID_W'(i) : win_id;
         win_prio = take_s ? prio_vec[(i-1)*PRIO_W +: PRIO_W] : win_prio;
      end
   end

endmodule

// File: rtl/vigna_irq_ctrl.sv
// -----------------------------------------------------------------------------
// vigna_irq_ctrl
// External-interrupt controller for the Vigna core. Collects NUM_SRC sources
// (level or edge per source), arbitrates by priority against a threshold,
// and offers claim/complete over a valid/ready slave port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   src_irq [NUM_SRC:1]   raw sources, bit i = source ID i, synchronous to clk
//   s_valid/s_ready       bus request / one-cycle response pulse
//   s_addr, s_wdata       byte address, write data
//   s_wstrb               nonzero = write (full word)
//   s_rdata               read data, valid while s_ready=1
//   ext_irq               registered interrupt request to the core
//   irq_id [4:0]          registered winner ID, only when VIGNA_IRQ_ID_OUT_EN
//                         is defined
// -----------------------------------------------------------------------------
module vigna_irq_ctrl
   import vigna_irq_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned PRIO_W    = 3,
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC:1]   src_irq,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [31:0]        s_addr,
   input  logic [31:0]        s_wdata,
   input  logic [3:0]         s_wstrb,
   output logic [31:0]        s_rdata,
   output logic               ext_irq
`ifdef VIGNA_IRQ_ID_OUT_EN
   ,output logic [ID_W-1:0]   irq_id
`endif
);

   logic [NUM_SRC:1]             pending_r;
   logic [NUM_SRC:1]             enable_r;
   logic [NUM_SRC:1]             mode_r;
   logic [NUM_SRC:1]             in_service_r;
   logic [NUM_SRC:1]             prev_r;
   logic [NUM_SRC:1][PRIO_W-1:0] prio_r;
   logic [PRIO_W-1:0]            thresh_r;
   logic                         s_ready_r;
   logic [31:0]                  s_rdata_r;
   logic                         ext_irq_r;

   logic                         acc_s, rd_s, wr_s, win_hit_s;
   logic                         claim_s, cpl_s, prio_hit_s;
   logic [11:0]                  off_s, prio_off_s;
   logic [9:0]                   prio_word_s;
   logic [ID_W-1:0]              prio_idx_s;
   logic [NUM_SRC:1]             cand_s, rise_s, claim_clr_s, cpl_clr_s;
   logic [NUM_SRC:1]             in_service_nxt_s, pending_nxt_s;
   logic [ID_W-1:0]              win_id_s;
   logic [PRIO_W-1:0]            win_prio_s;
   logic [31:0]                  rdata_s;
   logic                         unused_s;

   // An access executes only in the cycle before its response pulse.
   assign acc_s       = s_valid & ~s_ready_r;
   assign wr_s        = acc_s & (s_wstrb != 4'b0000);
   assign rd_s        = acc_s & (s_wstrb == 4'b0000);
   assign win_hit_s   = (s_addr[31:12] == BASE_ADDR[31:12]);
   assign off_s       = s_addr[11:0];
   assign prio_off_s  = off_s - OFF_PRIO_BASE;
   assign prio_word_s = prio_off_s[11:2];
   assign prio_idx_s  = prio_word_s[ID_W-1:0];
   assign prio_hit_s  = win_hit_s && (off_s >= OFF_PRIO_BASE) &&
                        (prio_off_s[1:0] == 2'b00) &&
                        (prio_word_s >= 10'd1) && (prio_word_s <= 10'(NUM_SRC));
   assign claim_s     = rd_s & win_hit_s & (off_s == OFF_CLAIM);
   assign cpl_s       = wr_s & win_hit_s & (off_s == OFF_CLAIM);
   assign unused_s    = ^{s_wdata, win_prio_s};

   // Candidate mask: requesting, enabled, not in service, above threshold.
   always_comb begin
      cand_s = {NUM_SRC{1'b0}};
      for (int i = 1; i <= NUM_SRC; i++) begin
         cand_s[i] = pending_r[i] & enable_r[i] & ~in_service_r[i] &
                     (prio_r[i] > thresh_r);
      end
   end

   vigna_irq_arbiter #(
      .NUM_SRC (NUM_SRC),
      .PRIO_W  (PRIO_W)
   ) u_arbiter (
      .cand     (cand_s),
      .prio_vec (prio_r),
      .win_id   (win_id_s),
      .win_prio (win_prio_s)
   );

   // Next pending / in-service state. Edge set beats a same-cycle claim;
   // level sources are masked by the post-update in-service bit.
   always_comb begin
      claim_clr_s = {NUM_SRC{1'b0}};
      cpl_clr_s   = {NUM_SRC{1'b0}};
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (claim_s && (win_id_s == ID_W'(i))) begin
            claim_clr_s[i] = 1'b1;
         end else begin
            claim_clr_s[i] = 1'b0;
         end
         if (cpl_s && (s_wdata[ID_W-1:0] == ID_W'(i))) begin
            cpl_clr_s[i] = 1'b1;
         end else begin
            cpl_clr_s[i] = 1'b0;
         end
      end
      rise_s           = src_irq & ~prev_r;
      in_service_nxt_s = (in_service_r | claim_clr_s) & ~cpl_clr_s;
      pending_nxt_s    = (mode_r & (rise_s | (pending_r & ~claim_clr_s))) |
                         (~mode_r & src_irq & ~in_service_nxt_s);
   end

   // Read data mux; a claim read returns the current winner.
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (!win_hit_s) begin
         rdata_s = 32'h0000_0000;
      end else begin
         case (off_s)
            OFF_PENDING: rdata_s = 32'({pending_r, 1'b0});
            OFF_ENABLE:  rdata_s = 32'({enable_r, 1'b0});
            OFF_MODE:    rdata_s = 32'({mode_r, 1'b0});
            OFF_THRESH:  rdata_s = 32'(thresh_r);
            OFF_CLAIM:   rdata_s = 32'(win_id_s);
            default: begin
               for (int i = 1; i <= NUM_SRC; i++) begin
                  if (prio_hit_s && (prio_idx_s == ID_W'(i))) begin
                     rdata_s = 32'(prio_r[i]);
                  end else begin
                     rdata_s = rdata_s;
                  end
               end
            end
         endcase
      end
   end

   // Bus response: one-cycle ready pulse with the read data captured alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready_r <= 1'b0;
         s_rdata_r <= 32'h0000_0000;
      end else begin
         s_ready_r <= acc_s;
         s_rdata_r <= rd_s ? rdata_s : 32'h0000_0000;
      end
   end

   // Interrupt state: source history, pending, in-service and the request line.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r       <= {NUM_SRC{1'b0}};
         pending_r    <= {NUM_SRC{1'b0}};
         in_service_r <= {NUM_SRC{1'b0}};
         ext_irq_r    <= 1'b0;
      end else begin
         prev_r       <= src_irq;
         pending_r    <= pending_nxt_s;
         in_service_r <= in_service_nxt_s;
         ext_irq_r    <= (win_id_s != ID_NONE);
      end
   end

   // Software-visible configuration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_r <= {NUM_SRC{1'b0}};
         mode_r   <= {NUM_SRC{1'b0}};
         thresh_r <= {PRIO_W{1'b0}};
         prio_r   <= {(NUM_SRC*PRIO_W){1'b0}};
      end else if (wr_s && win_hit_s) begin
         case (off_s)
            OFF_ENABLE: enable_r <= s_wdata[NUM_SRC:1];
            OFF_MODE:   mode_r   <= s_wdata[NUM_SRC:1];
            OFF_THRESH: thresh_r <= s_wdata[PRIO_W-1:0];
            default: begin
               for (int i = 1; i <= NUM_SRC; i++) begin
                  if (prio_hit_s && (prio_idx_s == ID_W'(i))) begin
                     prio_r[i] <= s_wdata[PRIO_W-1:0];
                  end else begin
                     prio_r[i] <= prio_r[i];
                  end
               end
            end
         endcase
      end else begin
         enable_r <= enable_r;
      end
   end

   assign s_ready = s_ready_r;
   assign s_rdata = s_rdata_r;
   assign ext_irq = ext_irq_r;

`ifdef VIGNA_IRQ_ID_OUT_EN
   logic [ID_W-1:0] irq_id_r;

   // Vectoring ID, registered with ext_irq so the two always agree.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_id_r <= ID_NONE;
      end else begin
         irq_id_r <= win_id_s;
      end
   end

   assign irq_id = irq_id_r;
`else
   // No vectoring output: software obtains the ID through a claim read.
`endif

endmodule
